sram_arb_boot: RTL and testbench
================================

# sram_arb_boot

Controller for a single-port 32x1024 SSRAM (`sram_32_1024_freepdk45`) shared as a unified instruction/data memory. After reset it runs a boot phase. In that phase it writes a stream of words into the SRAM from word address `BOOT_BASE` upward, holding the core in reset. It then releases `core_rstn` and arbitrates OBI-style fetch and LSU requests onto the SRAM, round-robin. It sits between `riscv_core` and the SRAM macro, replacing the separate per-memory wrappers and the bench-side flashing logic.

## Interface
- `ADDR_W`, 10: SRAM word-address width (1024 words).
- `DATA_W`, 32: word width.
- `BOOT_BASE`, 0: first SRAM word index written during boot.
- `CLK` in 1: single clock; all state updates on posedge.
- `RSTn` in 1: reset, synchronous and active-low.
- `ld_valid` in 1: boot stream word valid.
- `ld_data` in 32: boot stream word.
- `ld_last` in 1: marks the final boot word.
- `ld_ready` out 1: boot stream accept.
- `core_rstn` out 1: core reset (low during boot).
- `boot_done` out 1: high in RUN.
- `i_req`, `i_addr[31:0]`, `i_we`, `i_wdata[31:0]` in: fetch-port address phase.
- `i_gnt`, `i_rvalid`, `i_rdata[31:0]` out: fetch-port grant and response.
- `d_req`, `d_addr[31:0]`, `d_we`, `d_wdata[31:0]` in: LSU-port address phase.
- `d_gnt`, `d_rvalid`, `d_rdata[31:0]` out: LSU-port grant and response.
- `csb`, `web` out 1: SRAM chip select and write enable, both active-low.
- `addr` out ADDR_W: SRAM word address.
- `din` out 32: SRAM write data.
- `dout` in 32: SRAM read data.

## Operation
- States: `LOAD` and `RUN`. While RSTn=0 the next state is `LOAD`, the boot counter `wptr` is set to BOOT_BASE, and pending responses are dropped.
- Reset output values: `core_rstn`=0, `boot_done`=0, `ld_ready`=0, all gnt/rvalid=0, all rdata=0, `csb`=1, `web`=1, `addr`=0, `din`=0.
- `LOAD` behaviour:
  - `ld_ready`=1 and both gnt=0; one word is accepted per cycle.
  - On `ld_valid`, drive `csb`=0, `web`=0, `addr`=`wptr`, `din`=`ld_data`, then increment `wptr`.
  - Go to `RUN` after a word accepted with `ld_last`=1.
  - Also go to `RUN` after writing word 2^ADDR_W-1; it is treated as last and `wptr` never wraps.
- `RUN` behaviour:
  - `core_rstn`=1, `boot_done`=1, `ld_ready`=0.
  - `RUN` is left only through reset.
- Arbitration in `RUN` (combinational grant):
  - Only one requester: it is granted in the same cycle.
  - Both requesting: grant the port not granted last. A flag `last_d` updates on every grant; its reset value is 0, so fetch wins the first tie.
  - The granted port drives `csb`=0, `web`=!we, `addr`=req_addr[ADDR_W+1:2], `din`=wdata.
  - Upper address bits and bits [1:0] are ignored, so addresses alias.
  - With no grant, `csb`=1.
- Response:
  - A registered tag records {valid, port, we}.
  - The cycle after a grant, the tagged port's rvalid=1.
  - rdata=`dout` for a read; rdata=0 for a write. The other port's rdata stays 0.
- Writes are full-word only; there are no byte enables.

## Timing
- Grant: 0-cycle latency. The address phase completes on req&&gnt.
- Read data: the SRAM samples its inputs at posedge N, and `dout` is valid through cycle N+1. rvalid/rdata are combinational from the tag and `dout` in cycle N+1.
- Throughput: one access per cycle, back-to-back reads included.
- Boot: the last word is written at posedge N; `core_rstn` rises in cycle N+1. A core request in that cycle can be granted, and its read returns the just-written data.
- A request held low or high across reset: no grant while RSTn=0, and no grant in `LOAD`.
- Reset mid-`RUN`: the next cycle is `LOAD` with `core_rstn`=0. A response pending from the previous cycle is suppressed (rvalid=0).

## Structure
- Shared package `riscv_pkg`:
  - enum `sram_arb_state_t` {LOAD, RUN};
  - struct `sram_resp_tag_t` {valid, port, we};
  - constants `SRAM_WORDS`=1024 and `SRAM_ADDR_W`=10.
- One sub-module, `rr_arb2`: 2-input round-robin arbiter with a `last` flag, shared with future multi-master blocks.

## Test plan
- Boot of 3 words (0xA, 0xB, 0xC with `ld_last`) -> writes to addresses 0..2 on consecutive cycles; `core_rstn` rises in the cycle after the third write.
- Boot stream with gaps (ld_valid low for 2 cycles between words) -> `wptr` holds; no SRAM write in the gap cycles.
- Fetch read of 0x4 after boot -> `i_gnt` in the same cycle, `i_rvalid`=1 next cycle with `i_rdata`=0xB.
- Both ports requesting reads every cycle for 4 cycles (i:0x0, d:0x8) -> grants alternate I, D, I, D; each rvalid lands on the correct port with 0xA or 0xC.
- LSU write 0x1234 to 0x10 followed by a fetch read of 0x10 -> `d_rvalid` with `d_rdata`=0, then `i_rdata`=0x1234.
- RSTn pulsed low for 1 cycle during an outstanding read -> no rvalid, `core_rstn`=0, `ld_ready`=1 after release, and the next boot word is written at address 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the unified SRAM controller and its arbiter.
package riscv_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } sram_arb_state_t;

    typedef struct packed {
        logic valid;
        logic port;
        logic we;
    } sram_resp_tag_t;

    localparam int SRAM_WORDS  = 1024;
    localparam int SRAM_ADDR_W = 10;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    function automatic logic [SRAM_ADDR_W-1:0] word_index(input logic [31:0] byte_addr);
        return byte_addr[SRAM_ADDR_W+1:2];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with combinational grant; port 0 wins the first tie.
module rr_arb2 (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    // High when port 0 took the most recent grant, so a tie goes to port 1.
    logic last_r;

    // Grant selection: a lone requester wins outright, a tie alternates.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (req0 && req1) begin
                gnt0 = !last_r;
                gnt1 = last_r;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end else begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    // Remember the winner of every grant.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_r <= 1'b0;
        end else if (gnt0 || gnt1) begin
            last_r <= gnt0;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/sram_arb_boot.sv
// Boots a single-port SSRAM from a word stream, then shares it between the
// fetch and LSU ports of the core with round-robin arbitration.
module sram_arb_boot
    import riscv_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int BOOT_BASE = 0
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              core_rstn,
    output logic              boot_done,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [31:0]       d_addr,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              csb,
    output logic              web,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] dout
);

    sram_arb_state_t state_r;
    logic [ADDR_W-1:0] wptr_r;
    sram_resp_tag_t    tag_r;

    logic load_s, run_s, accept_s, i_gnt_s, d_gnt_s, sel_we_s;
    logic unused_addr_bits_s;

    // Everything is qualified by RSTn so the outputs hold reset values while it is low.
    assign load_s   = RSTn && (state_r == LOAD);
    assign run_s    = RSTn && (state_r == RUN);
    assign accept_s = load_s && ld_valid;

    assign unused_addr_bits_s = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};

    rr_arb2 u_arb (
        .clk  (CLK),
        .rstn (RSTn),
        .en   (run_s),
        .req0 (i_req),
        .req1 (d_req),
        .gnt0 (i_gnt_s),
        .gnt1 (d_gnt_s)
    );

    // Boot sequencing and response tag; the last SRAM word ends boot even without ld_last.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_r <= LOAD;
            wptr_r  <= ADDR_W'(BOOT_BASE);
            tag_r   <= '{valid: 1'b0, port: 1'b0, we: 1'b0};
        end else begin
            case (state_r)
                LOAD: begin
                    if (accept_s) begin
                        if (ld_last || (wptr_r == {ADDR_W{1'b1}})) begin
                            state_r <= RUN;
                        end else begin
                            wptr_r <= wptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                RUN:     state_r <= RUN;
                default: state_r <= LOAD;
            endcase
            tag_r <= '{valid: i_gnt_s || d_gnt_s, port: d_gnt_s ? PORT_D : PORT_I, we: sel_we_s};
        end
    end

    // SRAM port mux: boot writer in LOAD, arbitrated core port in RUN.
    always_comb begin
        csb      = 1'b1;
        web      = 1'b1;
        addr     = '0;
        din      = '0;
        sel_we_s = 1'b0;
        if (accept_s) begin
            csb  = 1'b0;
            web  = 1'b0;
            addr = wptr_r;
            din  = ld_data;
        end else if (i_gnt_s) begin
            csb      = 1'b0;
            web      = !i_we;
            addr     = i_addr[ADDR_W+1:2];
            din      = i_wdata;
            sel_we_s = i_we;
        end else if (d_gnt_s) begin
            csb      = 1'b0;
            web      = !d_we;
            addr     = d_addr[ADDR_W+1:2];
            din      = d_wdata;
            sel_we_s = d_we;
        end else begin
            csb = 1'b1;
        end
    end

    assign ld_ready  = load_s;
    assign core_rstn = run_s;
    assign boot_done = run_s;
    assign i_gnt     = i_gnt_s;
    assign d_gnt     = d_gnt_s;

    // Write responses carry zero data; reads pass the macro output straight through.
    assign i_rvalid = RSTn && tag_r.valid && (tag_r.port == PORT_I);
    assign d_rvalid = RSTn && tag_r.valid && (tag_r.port == PORT_D);
    assign i_rdata  = (i_rvalid && !tag_r.we) ? dout : '0;
    assign d_rdata  = (d_rvalid && !tag_r.we) ? dout : '0;

endmodule

// File: tb/tb_sram_arb_boot.sv
// Bench for sram_arb_boot: directed boot/arbitration scenarios plus random traffic
// checked every cycle against a transaction-level model of the memory and ports.
module tb_sram_arb_boot;

    logic tb_CLK = 1'b0;
    always #5 tb_CLK = ~tb_CLK;

    logic        RSTn, ld_valid, ld_last, ld_ready, core_rstn, boot_done;
    logic [31:0] ld_data;
    logic        i_req, i_we, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_wdata, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        csb, web;
    logic [9:0]  addr;
    logic [31:0] din, dout;

    sram_arb_boot dut (
        .CLK(tb_CLK), .RSTn(RSTn),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .core_rstn(core_rstn), .boot_done(boot_done),
        .i_req(i_req), .i_addr(i_addr), .i_we(i_we), .i_wdata(i_wdata),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .csb(csb), .web(web), .addr(addr), .din(din), .dout(dout)
    );

    // Behavioural single-port SSRAM macro.
    logic [31:0] sram [0:1023];
    always @(posedge tb_CLK) begin
        if (!csb) begin
            if (!web) sram[addr] <= din;
            else      dout <= sram[addr];
        end
    end

    // Reference model: memory image, boot pointer, pending response, last winner.
    bit          m_run;
    int          m_wptr;
    logic [31:0] m_mem [0:1023];
    bit          p_valid, p_port, p_we;
    logic [31:0] p_data;
    int          m_last;   // -1 none since reset, 0 fetch, 1 LSU

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check one cycle's outputs, advance the model past the coming edge, move to next negedge.
    task automatic cycle();
        bit          eg_i, eg_d, e_iv, e_dv, we;
        logic [31:0] e_ir, e_dr, wd;
        logic [63:0] e_sram;
        logic [2:0]  e_stat;
        int          a;
        #1;
        eg_i = 0; eg_d = 0; e_iv = 0; e_dv = 0; e_ir = 0; e_dr = 0;
        e_stat = 3'b000;
        e_sram = {1'b1, 1'b1, 10'd0, 32'd0};
        if (RSTn) begin
            if (p_valid) begin
                if (p_port) begin e_dv = 1; e_dr = p_data; end
                else        begin e_iv = 1; e_ir = p_data; end
            end
            if (!m_run) begin
                e_stat = 3'b001;
                if (ld_valid) e_sram = {1'b0, 1'b0, 10'(m_wptr), ld_data};
            end else begin
                e_stat = 3'b110;
                if (i_req && d_req) begin
                    if (m_last == 0) eg_d = 1; else eg_i = 1;
                end else begin
                    eg_i = i_req; eg_d = d_req;
                end
                if (eg_i) e_sram = {1'b0, !i_we, i_addr[11:2], i_wdata};
                if (eg_d) e_sram = {1'b0, !d_we, d_addr[11:2], d_wdata};
            end
        end
        chk("status", {core_rstn, boot_done, ld_ready}, e_stat);
        chk("gnt", {i_gnt, d_gnt}, {eg_i, eg_d});
        chk("rvalid", {i_rvalid, d_rvalid}, {e_iv, e_dv});
        chk("i_rdata", i_rdata, e_ir);
        chk("d_rdata", d_rdata, e_dr);
        chk("sram_if", {csb, web, addr, din}, e_sram);
        if (!RSTn) begin
            m_run = 0; m_wptr = 0; p_valid = 0; m_last = -1;
        end else begin
            p_valid = 0;
            if (!m_run) begin
                if (ld_valid) begin
                    m_mem[m_wptr] = ld_data;
                    if (ld_last || m_wptr == 1023) m_run = 1;
                    else m_wptr++;
                end
            end else if (eg_i || eg_d) begin
                a  = eg_d ? int'(d_addr[11:2]) : int'(i_addr[11:2]);
                we = eg_d ? d_we : i_we;
                wd = eg_d ? d_wdata : i_wdata;
                p_valid = 1; p_port = eg_d; p_we = we;
                p_data  = we ? 32'd0 : m_mem[a];
                if (we) m_mem[a] = wd;
                m_last = eg_d ? 1 : 0;
            end
        end
        @(negedge tb_CLK);
    endtask

    task automatic rand_cycle();
        i_req   = 1'($urandom_range(0, 1));
        i_we    = 1'($urandom_range(0, 1));
        i_addr  = $urandom & 32'hF000_007F;
        i_wdata = $urandom;
        d_req   = 1'($urandom_range(0, 1));
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom & 32'hF000_007F;
        d_wdata = $urandom;
        ld_valid = 1'($urandom_range(0, 1));
        ld_data  = $urandom;
        ld_last  = 1'($urandom_range(0, 1));
        cycle();
    endtask

    task automatic load_word(input logic [31:0] w, input bit last);
        ld_valid = 1'b1; ld_data = w; ld_last = last;
        cycle();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) begin sram[k] = 32'd0; m_mem[k] = 32'd0; end
        dout = 32'd0;
        m_run = 0; m_wptr = 0; p_valid = 0; p_port = 0; p_we = 0; p_data = 32'd0; m_last = -1;
        RSTn = 1'b0; ld_valid = 1'b0; ld_data = 32'd0; ld_last = 1'b0;
        i_req = 1'b1; i_addr = 32'h8; i_we = 1'b0; i_wdata = 32'd0;
        d_req = 1'b1; d_addr = 32'h0; d_we = 1'b0; d_wdata = 32'd0;
        @(negedge tb_CLK);

        // Requests held high through reset and boot are never granted.
        cycle(); cycle();
        RSTn = 1'b1; d_req = 1'b0;
        load_word(32'hA, 1'b0);
        load_word(32'hB, 1'b0);
        load_word(32'hC, 1'b1);
        // First RUN cycle: the held fetch of 0x8 reads back the just-written 0xC.
        cycle();
        i_addr = 32'h4; cycle();
        i_req = 1'b0; cycle();

        // LSU write then fetch read of the same word, then an LSU read.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h1234; cycle();
        d_req = 1'b0; i_req = 1'b1; i_we = 1'b0; i_addr = 32'h10; cycle();
        i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4; cycle();

        // Contention on every cycle: grants alternate starting with fetch.
        i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_addr = 32'h8;
        repeat (4) cycle();
        i_req = 1'b0; d_req = 1'b0; cycle();

        repeat (300) rand_cycle();

        // One-cycle reset pulse while a read is outstanding.
        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0; d_req = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        cycle();
        RSTn = 1'b0; cycle();
        RSTn = 1'b1;
        load_word(32'h11, 1'b0);
        cycle(); cycle();
        load_word(32'h22, 1'b0);
        load_word(32'h33, 1'b1);
        repeat (150) rand_cycle();

        // Full-memory boot with no ld_last ends at the top word.
        RSTn = 1'b0; i_req = 1'b0; d_req = 1'b0; ld_valid = 1'b0; cycle();
        RSTn = 1'b1;
        for (int k = 0; k < 1024; k++) load_word($urandom, 1'b0);
        ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF; cycle();
        ld_valid = 1'b0;
        repeat (300) rand_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
